// File: rtl/dadda_mac_pkg.sv
// Shared constants and types for the dadda_mac multiply-accumulate stage.
// Optional build macro used by this slice: DADDA_MAC_SAT_EN (saturating accumulate).
package dadda_mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/dadda_mac_if.sv
// Operand-in / result-out handshake bundle for dadda_mac.
// The slave side is the MAC; the master side drives operands and consumes results.
interface dadda_mac_if #(
    parameter int ACC_W = 16
) ();
    import dadda_mac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/dadda_multiplier.sv
// Combinational 4x4 unsigned Dadda multiplier.
// Partial products are reduced 4 -> 3 -> 2 rows with half/full adders,
// then a single carry-propagate add forms the 8-bit product.
module dadda_multiplier
    import dadda_mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] s
);

    // {carry, sum} of a half adder
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // {carry, sum} of a full adder
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    logic [OP_W-1:0] pp_s [OP_W];   // pp_s[i][j] = a[j] & b[i], weight i+j
    logic [1:0] h1_s, h2_s, h3_s;
    logic [1:0] f1_s, f2_s, f3_s;
    logic [6:0] row0_s, row1_s;

    // Partial products, Dadda reduction and final carry-propagate add
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            pp_s[i] = a & {OP_W{b[i]}};
        end
        // Reduce to height 3: column 3 (4 bits) and column 4 (4 bits after carry)
        h1_s = ha(pp_s[0][3], pp_s[1][2]);
        h2_s = ha(pp_s[1][3], pp_s[2][2]);
        // Reduce to height 2
        h3_s = ha(pp_s[0][2], pp_s[1][1]);
        f1_s = fa(h1_s[0], pp_s[2][1], pp_s[3][0]);
        f2_s = fa(h2_s[0], pp_s[3][1], h1_s[1]);
        f3_s = fa(pp_s[2][3], pp_s[3][2], h2_s[1]);
        row0_s = {pp_s[3][3], f3_s[0], f2_s[0], f1_s[0], h3_s[0], pp_s[0][1], pp_s[0][0]};
        row1_s = {f3_s[1], f2_s[1], f1_s[1], h3_s[1], pp_s[2][0], pp_s[1][0], 1'b0};
        s = {1'b0, row0_s} + {1'b0, row1_s};
    end

endmodule

// File: rtl/dadda_mac.sv
// dadda_mac: streaming multiply-accumulate around the 4-bit Dadda multiplier.
// Each accepted operand pair is multiplied and registered, then LEN products
// are summed into an ACC_W-bit accumulator; the group sum is offered on the
// output handshake and held until taken.
// Build option: DADDA_MAC_SAT_EN clamps the accumulator at 2^ACC_W-1 instead
// of wrapping; out_ovf flags the overflow in both builds.
module dadda_mac
    import dadda_mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    dadda_mac_if.slave bus
);

    localparam int CNT_W = (LEN < 2) ? 1 : $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(LEN - 1);

    state_t              state_r, state_nx_s;
    logic [PROD_W-1:0]   prod_s, prod_r;
    logic                prod_v_r;
    logic [ACC_W-1:0]    acc_r, acc_nx_s;
    logic                ovf_r, ovf_nx_s;
    logic [ACC_W:0]      sum_s;
    logic [CNT_W-1:0]    icnt_r, acnt_r;
    logic [ACC_W-1:0]    out_acc_r;
    logic                out_ovf_r;
    logic                in_ready_s, accept_s, last_s, release_s;

    dadda_multiplier u_mult (
        .a (bus.in_a),
        .b (bus.in_b),
        .s (prod_s)
    );

    // Input handshake: only in RUN, only while the group still needs operands
    always_comb begin
        in_ready_s = (state_r == RUN) && (icnt_r != LEN_C) && !rst;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Accumulator update; the carry into bit ACC_W is the overflow event
    always_comb begin
        sum_s    = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_r};
        ovf_nx_s = ovf_r | sum_s[ACC_W];
`ifdef DADDA_MAC_SAT_EN
        if (ovf_nx_s) begin
            acc_nx_s = {ACC_W{1'b1}};
        end else begin
            acc_nx_s = sum_s[ACC_W-1:0];
        end
`else
        acc_nx_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state logic: finish the group on its last product, release on out_ready
    always_comb begin
        state_nx_s = state_r;
        last_s     = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (prod_v_r && (acnt_r == LEN_M1)) begin
                    state_nx_s = DONE;
                    last_s     = 1'b1;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = RUN;
                    release_s  = 1'b1;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Multiply stage: capture the product of each accepted pair
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r   <= {PROD_W{1'b0}};
            prod_v_r <= 1'b0;
        end else begin
            prod_v_r <= accept_s;
            if (accept_s) begin
                prod_r <= prod_s;
            end
        end
    end

    // Accumulate stage and group counters; cleared when the result is taken
    always_ff @(posedge clk) begin
        if (rst || release_s) begin
            acc_r  <= {ACC_W{1'b0}};
            ovf_r  <= 1'b0;
            icnt_r <= {CNT_W{1'b0}};
            acnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                icnt_r <= icnt_r + CNT_W'(1);
            end
            if (prod_v_r) begin
                acc_r  <= acc_nx_s;
                ovf_r  <= ovf_nx_s;
                acnt_r <= acnt_r + CNT_W'(1);
            end
        end
    end

    // Result registers: load the final sum as the group completes, then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_acc_r <= {ACC_W{1'b0}};
            out_ovf_r <= 1'b0;
        end else if (last_s) begin
            out_acc_r <= acc_nx_s;
            out_ovf_r <= ovf_nx_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == DONE);
    assign bus.out_acc   = out_acc_r;
    assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_dadda_mac.sv
// Directed self-checking bench for dadda_mac.
// u0: ACC_W=16 LEN=4, u1: ACC_W=8 LEN=4 (overflow), u2: ACC_W=16 LEN=1.
module tb_dadda_mac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   v0_cnt = 0;
    int   v0_base;

`ifdef DADDA_MAC_SAT_EN
    localparam logic [31:0] EXP_OVF_ACC = 32'd255;
`else
    localparam logic [31:0] EXP_OVF_ACC = 32'd132;
`endif

    always #5 clk = ~clk;

    dadda_mac_if #(.ACC_W(16)) if0 ();
    dadda_mac_if #(.ACC_W(8))  if1 ();
    dadda_mac_if #(.ACC_W(16)) if2 ();

    dadda_mac #(.ACC_W(16), .LEN(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    dadda_mac #(.ACC_W(8),  .LEN(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    dadda_mac #(.ACC_W(16), .LEN(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Count result-valid cycles of u0 for the single-pulse check
    always @(negedge clk) begin
        if (if0.out_valid === 1'b1) v0_cnt <= v0_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv0(input logic v, input logic [3:0] a, input logic [3:0] b);
        if0.in_valid = v; if0.in_a = a; if0.in_b = b;
    endtask

    task automatic drv1(input logic v, input logic [3:0] a, input logic [3:0] b);
        if1.in_valid = v; if1.in_a = a; if1.in_b = b;
    endtask

    task automatic drv2(input logic v, input logic [3:0] a, input logic [3:0] b);
        if2.in_valid = v; if2.in_a = a; if2.in_b = b;
    endtask

    initial begin
        drv0(1'b0, 4'd0, 4'd0); drv1(1'b0, 4'd0, 4'd0); drv2(1'b0, 4'd0, 4'd0);
        if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;

        // ---- reset state ----
        rst = 1'b1;
        tick(); tick();
        chk("rst_in_ready",  32'(if0.in_ready),  32'd0);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_acc",   32'(if0.out_acc),   32'd0);
        chk("rst_out_ovf",   32'(if0.out_ovf),   32'd0);
        chk("rst_in_ready2", 32'(if2.in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(if0.in_ready), 32'd1);

        // ---- basic sum: 15+225+0+14 = 254 ----
        drv0(1'b1, 4'd3, 4'd5);   tick();
        drv0(1'b1, 4'd15, 4'd15); tick();
        drv0(1'b1, 4'd0, 4'd9);   tick();
        drv0(1'b1, 4'd7, 4'd2);   #1;
        chk("basic_ready_last", 32'(if0.in_ready), 32'd1);
        tick();
        drv0(1'b0, 4'd0, 4'd0);   #1;
        chk("basic_ready_full", 32'(if0.in_ready),  32'd0);
        chk("basic_valid_t1",   32'(if0.out_valid), 32'd0);
        tick();
        chk("basic_valid_t2",   32'(if0.out_valid), 32'd1);
        chk("basic_acc",        32'(if0.out_acc),   32'd254);
        chk("basic_ovf",        32'(if0.out_ovf),   32'd0);
        chk("basic_ready_done", 32'(if0.in_ready),  32'd0);
        tick();
        chk("basic_valid_drop", 32'(if0.out_valid), 32'd0);
        chk("basic_ready_back", 32'(if0.in_ready),  32'd1);

        // ---- backpressure: hold result for 5 cycles ----
        if0.out_ready = 1'b0;
        drv0(1'b1, 4'd3, 4'd5);   tick();
        drv0(1'b1, 4'd15, 4'd15); tick();
        drv0(1'b1, 4'd0, 4'd9);   tick();
        drv0(1'b1, 4'd7, 4'd2);   tick();
        drv0(1'b0, 4'd0, 4'd0);   tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(if0.out_valid), 32'd1);
            chk("bp_acc_stable", 32'(if0.out_acc),   32'd254);
            chk("bp_ready_low",  32'(if0.in_ready),  32'd0);
            tick();
        end
        if0.out_ready = 1'b1; #1;
        chk("bp_valid_release", 32'(if0.out_valid), 32'd1);
        tick();
        chk("bp_ready_next",  32'(if0.in_ready),  32'd1);
        chk("bp_valid_clear", 32'(if0.out_valid), 32'd0);

        // ---- bubbles: 1+4+9+16 = 30, exactly one valid pulse ----
        v0_base = v0_cnt;
        drv0(1'b1, 4'd1, 4'd1); tick();
        drv0(1'b0, 4'd0, 4'd0); tick();
        drv0(1'b1, 4'd2, 4'd2); tick();
        drv0(1'b0, 4'd0, 4'd0); tick(); tick();
        drv0(1'b1, 4'd3, 4'd3); tick();
        drv0(1'b0, 4'd0, 4'd0); tick(); tick(); tick();
        drv0(1'b1, 4'd4, 4'd4); tick();
        drv0(1'b0, 4'd0, 4'd0); tick();
        chk("bub_valid", 32'(if0.out_valid), 32'd1);
        chk("bub_acc",   32'(if0.out_acc),   32'd30);
        tick(); tick(); tick(); tick();
        chk("bub_pulses", 32'(v0_cnt - v0_base), 32'd1);
        chk("bub_ovf",    32'(if0.out_ovf),      32'd0);

        // ---- overflow, ACC_W=8: 4 x 225 = 900 ----
        drv1(1'b1, 4'd15, 4'd15); tick(); tick(); tick(); tick();
        drv1(1'b0, 4'd0, 4'd0);   tick();
        chk("ovf_valid", 32'(if1.out_valid), 32'd1);
        chk("ovf_acc",   32'(if1.out_acc),   EXP_OVF_ACC);
        chk("ovf_flag",  32'(if1.out_ovf),   32'd1);
        tick();
        chk("ovf_valid_drop", 32'(if1.out_valid), 32'd0);

        // ---- LEN=1 back-to-back groups: 225 then 6 ----
        drv2(1'b1, 4'd15, 4'd15); #1;
        chk("l1_ready0", 32'(if2.in_ready), 32'd1);
        tick();
        drv2(1'b1, 4'd2, 4'd3);   #1;
        chk("l1_ready_full", 32'(if2.in_ready),  32'd0);
        chk("l1_valid_t1",   32'(if2.out_valid), 32'd0);
        tick();
        chk("l1_valid_a", 32'(if2.out_valid), 32'd1);
        chk("l1_acc_a",   32'(if2.out_acc),   32'd225);
        chk("l1_ovf_a",   32'(if2.out_ovf),   32'd0);
        tick();
        chk("l1_valid_a_drop", 32'(if2.out_valid), 32'd0);
        chk("l1_ready_again",  32'(if2.in_ready),  32'd1);
        tick();
        drv2(1'b0, 4'd0, 4'd0);   #1;
        chk("l1_valid_b_t1", 32'(if2.out_valid), 32'd0);
        tick();
        chk("l1_valid_b", 32'(if2.out_valid), 32'd1);
        chk("l1_acc_b",   32'(if2.out_acc),   32'd6);
        tick();

        // ---- reset mid-group: discard 2 x 225, then 4 x 2 = 8 ----
        drv0(1'b1, 4'd15, 4'd15); tick(); tick();
        drv0(1'b0, 4'd0, 4'd0);
        rst = 1'b1; #1;
        chk("mid_rst_ready", 32'(if0.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        drv0(1'b1, 4'd1, 4'd2); #1;
        chk("mid_ready_after", 32'(if0.in_ready), 32'd1);
        tick(); tick(); tick(); tick();
        drv0(1'b0, 4'd0, 4'd0); tick();
        chk("mid_valid", 32'(if0.out_valid), 32'd1);
        chk("mid_acc",   32'(if0.out_acc),   32'd8);
        chk("mid_ovf",   32'(if0.out_ovf),   32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
